cmd_frame_parser: RTL and testbench

- Synchronous, parametrised successor to the fixed AA/SEL/data/55 command decoder.
- Takes bytes from the UART receiver and parses variable-length command frames: header, experiment select, length, 0..MAX_PAYLOAD payload bytes, optional XOR checksum, trailer.
- Publishes experiment select and payload atomically, with a one-cycle strobe, and reports malformed or stalled frames.
- Sits between the UART byte receiver and the experiment-select / input-mux logic.

---
 rtl/cmd_frame_parser.sv | 149 ++++++++++++++
 tb/tb_cmd_frame_parser.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_frame_parser.sv
// Variable-length command frame parser for the UART byte stream.
// Publishes the experiment select and payload of each good frame and flags malformed or stalled ones.
module cmd_frame_parser #(
    parameter int         MAX_PAYLOAD = 2,
    parameter logic [7:0] HEADER      = 8'hAA,
    parameter logic [7:0] TRAILER     = 8'h55,
    parameter bit         CHK_EN      = 1'b1,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic                     tclk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [7:0]               exp_sel,
    output logic [8*MAX_PAYLOAD-1:0] payload,
    output logic [3:0]               payload_len,
    output logic                     key_mode,
    output logic                     frame_valid,
    output logic                     frame_err,
    output logic [1:0]               err_code
);

    localparam int PW = 8 * MAX_PAYLOAD;
    localparam int CW = $clog2(TIMEOUT_CYC);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SEL  = 3'd1;
    localparam logic [2:0] ST_LEN  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_CHK  = 3'd4;
    localparam logic [2:0] ST_TAIL = 3'd5;

    localparam logic [2:0]    ST_AFTER = CHK_EN ? ST_CHK : ST_TAIL;
    localparam logic [7:0]    MAX_LEN  = 8'(MAX_PAYLOAD);
    // The abort fires on the edge where the idle count would reach TIMEOUT_CYC-1.
    localparam logic [CW-1:0] TERM     = CW'(TIMEOUT_CYC - 2);

    localparam logic [1:0] ERR_TIMEOUT = 2'b00;
    localparam logic [1:0] ERR_LENGTH  = 2'b01;
    localparam logic [1:0] ERR_CHKSUM  = 2'b10;
    localparam logic [1:0] ERR_TRAILER = 2'b11;

    logic [2:0]    state;
    logic [CW-1:0] tcnt;
    logic [7:0]    sh_sel;
    logic [3:0]    sh_len;
    logic [3:0]    data_left;
    logic [PW-1:0] sh_pay;
    logic [PW-1:0] sh_next;
    logic [7:0]    chk;

    if (MAX_PAYLOAD > 1) begin : g_shift
        assign sh_next = {sh_pay[PW-9:0], rx_data};
    end else begin : g_single
        assign sh_next = rx_data;
    end

    always_ff @(posedge tclk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            tcnt        <= '0;
            sh_sel      <= '0;
            sh_len      <= '0;
            data_left   <= '0;
            sh_pay      <= '0;
            chk         <= '0;
            exp_sel     <= '0;
            payload     <= '0;
            payload_len <= '0;
            key_mode    <= 1'b1;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= ERR_TIMEOUT;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            if (state == ST_IDLE || rx_valid) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + CW'(1);
            end

            if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_data == HEADER) begin
                            state <= ST_SEL;
                        end
                    end
                    ST_SEL: begin
                        sh_sel <= rx_data;
                        chk    <= rx_data;
                        state  <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (rx_data > MAX_LEN) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LENGTH;
                            state     <= ST_IDLE;
                        end else begin
                            sh_len    <= rx_data[3:0];
                            data_left <= rx_data[3:0];
                            chk       <= chk ^ rx_data;
                            sh_pay    <= '0;
                            state     <= (rx_data == 8'd0) ? ST_AFTER : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        sh_pay    <= sh_next;
                        chk       <= chk ^ rx_data;
                        data_left <= data_left - 4'd1;
                        if (data_left == 4'd1) begin
                            state <= ST_AFTER;
                        end
                    end
                    ST_CHK: begin
                        if (rx_data != chk) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHKSUM;
                            state     <= ST_IDLE;
                        end else begin
                            state <= ST_TAIL;
                        end
                    end
                    ST_TAIL: begin
                        if (rx_data == TRAILER) begin
                            exp_sel     <= sh_sel;
                            payload     <= sh_pay;
                            payload_len <= sh_len;
                            key_mode    <= (sh_len == 4'd0);
                            frame_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_TRAILER;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE && tcnt == TERM) begin
                frame_err <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                state     <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Scoreboard bench for cmd_frame_parser: a frame-level reference model predicts every pulse
// and its cycle; a monitor pops predictions and also checks published outputs hold between commits.
module tb_cmd_frame_parser;

    localparam int         MAXP = 2;
    localparam int         PW   = 8 * MAXP;
    localparam int         TO   = 100;
    localparam bit         CHK  = 1'b1;
    localparam logic [7:0] HDR  = 8'hAA;
    localparam logic [7:0] TRL  = 8'h55;

    logic          tclk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    exp_sel;
    logic [PW-1:0] payload;
    logic [3:0]    payload_len;
    logic          key_mode;
    logic          frame_valid;
    logic          frame_err;
    logic [1:0]    err_code;

    cmd_frame_parser #(
        .MAX_PAYLOAD (MAXP),
        .HEADER      (HDR),
        .TRAILER     (TRL),
        .CHK_EN      (CHK),
        .TIMEOUT_CYC (TO)
    ) dut (
        .tclk        (tclk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .exp_sel     (exp_sel),
        .payload     (payload),
        .payload_len (payload_len),
        .key_mode    (key_mode),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_code    (err_code)
    );

    always #5 tclk = ~tclk;

    typedef struct {
        int            at;
        bit            is_err;
        logic [1:0]    code;
        logic [7:0]    sel;
        logic [PW-1:0] pay;
        logic [3:0]    len;
    } exp_t;

    exp_t       q[$];
    logic [7:0] fb[$];
    int         last_byte_cyc;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    logic [7:0]    pub_sel = '0;
    logic [PW-1:0] pub_pay = '0;
    logic [3:0]    pub_len = '0;
    logic          pub_key = 1'b1;

    always @(posedge tclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push_err(input int at, input logic [1:0] code);
        exp_t e;
        e.at = at; e.is_err = 1'b1; e.code = code;
        e.sel = '0; e.pay = '0; e.len = '0;
        q.push_back(e);
    endtask

    // Frame-level reference: collects frame bytes and judges them by position within the frame.
    task automatic model(input int at, input bit v, input logic [7:0] b);
        int n, len, total_len;
        logic [7:0] x;
        exp_t e;
        if (!v) begin
            if (fb.size() > 0 && at - last_byte_cyc == TO - 1) begin
                push_err(at, 2'b00);
                fb.delete();
            end
        end else begin
            last_byte_cyc = at;
            if (fb.size() == 0) begin
                if (b == HDR) fb.push_back(b);
            end else begin
                fb.push_back(b);
                n = fb.size();
                if (n == 3 && int'(b) > MAXP) begin
                    push_err(at, 2'b01);
                    fb.delete();
                end else if (n > 3) begin
                    len = int'(fb[2]);
                    total_len = 4 + len + (CHK ? 1 : 0);
                    if (CHK && n == total_len - 1) begin
                        x = 8'h00;
                        for (int i = 1; i <= n - 2; i++) x = x ^ fb[i];
                        if (b != x) begin
                            push_err(at, 2'b10);
                            fb.delete();
                        end
                    end else if (n == total_len) begin
                        if (b == TRL) begin
                            e.at = at; e.is_err = 1'b0; e.code = 2'b00;
                            e.sel = fb[1];
                            e.len = 4'(len);
                            e.pay = '0;
                            for (int i = 0; i < len; i++) e.pay = e.pay * 256 + PW'(fb[3 + i]);
                            q.push_back(e);
                        end else begin
                            push_err(at, 2'b11);
                        end
                        fb.delete();
                    end
                end
            end
        end
    endtask

    task automatic drive_cycle(input bit v, input logic [7:0] b);
        rx_valid = v;
        rx_data  = v ? b : 8'($urandom);
        model(cyc + 1, v, b);
        @(posedge tclk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        drive_cycle(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00);
    endtask

    task automatic send_list(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send(bytes[i]);
    endtask

    task automatic send_random_frame();
        logic [7:0] fr[$];
        int mode, len, keep;
        logic [7:0] x;
        mode = $urandom_range(0, 6);
        len  = $urandom_range(0, MAXP);
        fr.push_back(HDR);
        fr.push_back(8'($urandom));
        fr.push_back(8'(len));
        for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
        x = 8'h00;
        for (int i = 1; i < fr.size(); i++) x = x ^ fr[i];
        if (CHK) fr.push_back(x);
        fr.push_back(TRL);
        case (mode)
            1: fr[2] = 8'($urandom_range(MAXP + 1, 255));
            2: fr[3 + len] = fr[3 + len] ^ 8'($urandom_range(1, 255));
            3: fr[fr.size() - 1] = TRL + 8'($urandom_range(1, 255));
            5: for (int i = 0; i < 3; i++) fr.push_front(8'($urandom));
            default: ;
        endcase
        keep = (mode == 4) ? $urandom_range(1, fr.size() - 1) : fr.size();
        for (int i = 0; i < keep; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(fr[i]);
        end
        if (mode == 4) idle(TO + 2);
    endtask

    // Monitor: pops predictions on every pulse and checks that published outputs otherwise hold.
    always @(negedge tclk) begin
        exp_t e;
        if (rst) begin
            check("reset_outputs",
                  {exp_sel, payload, payload_len, key_mode, frame_valid, frame_err, err_code},
                  {8'h00, {PW{1'b0}}, 4'h0, 1'b1, 1'b0, 1'b0, 2'b00});
            pub_sel = '0; pub_pay = '0; pub_len = '0; pub_key = 1'b1;
        end else begin
            if (frame_valid || frame_err) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got valid=%0b err=%0b code=%0d want no pulse (cycle %0d)",
                             frame_valid, frame_err, err_code, cyc);
                end else begin
                    e = q.pop_front();
                    check("pulse_cycle", 64'(cyc), 64'(e.at));
                    check("pulse_kind", {frame_valid, frame_err}, {!e.is_err, e.is_err});
                    if (e.is_err) begin
                        check("err_code", err_code, e.code);
                    end else begin
                        pub_sel = e.sel; pub_pay = e.pay; pub_len = e.len;
                        pub_key = (e.len == 4'd0);
                    end
                end
            end else if (q.size() > 0 && q[0].at < cyc) begin
                e = q.pop_front();
                total++;
                bad++;
                $display("FAIL missing_pulse: got none want %s at cycle %0d (now %0d)",
                         e.is_err ? "frame_err" : "frame_valid", e.at, cyc);
            end
            check("published_outputs", {exp_sel, payload, payload_len, key_mode},
                  {pub_sel, pub_pay, pub_len, pub_key});
        end
    end

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge tclk);
        #1;
        rst = 1'b0;
        idle(2);

        send_list('{8'hAA, 8'h23, 8'h02, 8'h12, 8'h34, 8'h07, 8'h55});
        send_list('{8'hAA, 8'h41, 8'h00, 8'h41, 8'h55});
        send_list('{8'hAA, 8'h23, 8'h03});
        idle(2);
        send_list('{8'hAA, 8'h11, 8'h01, 8'h05, 8'h15, 8'h55});
        send_list('{8'hAA, 8'h23, 8'h02, 8'h12, 8'h34, 8'h00, 8'h55});
        send_list('{8'hAA, 8'h23, 8'h02, 8'h12, 8'h34, 8'h07, 8'h56});
        idle(3);

        send_list('{8'hAA, 8'h23});
        idle(TO + 5);
        send_list('{8'hAA, 8'h23});
        idle(TO - 2);
        send_list('{8'h00, 8'h23, 8'h55});
        idle(2);

        send_list('{8'h00, 8'hFF, 8'h55});
        send_list('{8'hAA, 8'h7E, 8'h01, 8'hAA, 8'hD5, 8'h55});

        send_list('{8'hAA, 8'h23, 8'h02, 8'h12});
        rst = 1'b1;
        fb.delete();
        q.delete();
        @(posedge tclk);
        #1;
        @(posedge tclk);
        #1;
        rst = 1'b0;
        idle(2);
        send_list('{8'hAA, 8'h5A, 8'h02, 8'hC3, 8'h3C, 8'h5A, 8'h55});
        idle(2);

        for (int k = 0; k < 300; k++) send_random_frame();
        idle(TO + 5);

        check("queue_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
